// File: rtl/re_map_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// re_map_ctrl_pkg
// Shared definitions for the resource-element mapping controller:
//   - FSM state encoding (IDLE, WRITE, GAP, DONE)
//   - SC_PER_PRB : subcarriers per physical resource block
//   - MAX_SYM    : largest legal symbol count per subframe
//   - ADDR_W     : subcarrier address width (covers 100 PRB * 12 = 1200)
//   - SYM_W      : symbol counter width
// ----------------------------------------------------------------------------
package re_map_ctrl_pkg;

   localparam int SC_PER_PRB = 12;
   localparam int MAX_SYM    = 14;
   localparam int ADDR_W     = 11;
   localparam int SYM_W      = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      GAP   = 2'd2,
      DONE  = 2'd3
   } re_map_state_e;

endpackage

// File: rtl/re_map_cnt.sv
// ----------------------------------------------------------------------------
// re_map_cnt
// Generic wrap counter. Counts 0..last, returning to 0 on the increment that
// follows count==last. clr has priority over en.
// Ports:
//   CLK, RST   clock, asynchronous active-low reset
//   en         advance the counter this cycle
//   clr        force the counter to 0
//   last       terminal value (wrap point)
//   count      current value
//   term       high while count==last
// ----------------------------------------------------------------------------
module re_map_cnt #(
   parameter int W = 4
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] last,
   output logic [W-1:0] count,
   output logic         term
);

   assign term = (count == last);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= term ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/re_map_ctrl.sv
// ----------------------------------------------------------------------------
// re_map_ctrl
// Maps a stream of precoded samples onto subcarrier addresses, one symbol
// (n_sc = 12 * nprb subcarriers) at a time, for nsym symbols per subframe.
// Between symbols a guard gap of GAP_CYC idle cycles follows each sym_done.
//
// Handshake: a sample transfers on a rising CLK edge where in_valid and
// in_ready are both high. in_valid may drop at any time (the symbol simply
// stalls, no timeout); in_ready is high only in WRITE and depends only on the
// FSM state, never on in_valid.
//
// Ports:
//   CLK, RST            clock, asynchronous active-low reset
//   start               one-cycle pulse, latches cfg_* and begins a subframe
//   cfg_nprb, cfg_nsym  PRB count (1..MAX_PRB), symbol count (1..14)
//   abort               synchronous kill of the running subframe
//   in_data/valid/ready sample input stream
//   wr_data/en/addr     registered write port (addr = subcarrier index)
//   sym_done            pulse the cycle after the last write of a symbol
//   re_done             pulse at end of subframe or on abort
//   busy                high in every state except IDLE
//   cfg_err             sticky illegal-configuration flag
//   fsm_state           FSM state for observation
// ----------------------------------------------------------------------------
module re_map_ctrl
   import re_map_ctrl_pkg::*;
#(
   parameter int DATA_W  = 18,
   parameter int MAX_PRB = 100,
   parameter int GAP_CYC = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   input  logic [6:0]        cfg_nprb,
   input  logic [3:0]        cfg_nsym,
   input  logic              abort,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] wr_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              sym_done,
   output logic              re_done,
   output logic              busy,
   output logic              cfg_err,
   output re_map_state_e     fsm_state
);

   // GAP_CYC is expected to be at least 1.
   localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

   re_map_state_e     state, state_next;

   logic [ADDR_W-1:0] n_sc;
   logic [SYM_W-1:0]  nsym;
   logic [ADDR_W-1:0] sc_cnt;
   logic [SYM_W-1:0]  sym_cnt;
   logic              sc_term, sym_term;
   logic [GAP_W-1:0]  gap_cnt;
   logic              final_sym;
   logic              last_q;

   logic              accept, sym_end, legal, launch, kill;
   logic              gap_run, gap_exit;

   assign in_ready  = (state == WRITE);
   assign busy      = (state != IDLE);
   assign fsm_state = state;

   assign accept  = in_valid && in_ready;
   assign sym_end = accept && sc_term;

   assign legal  = (int'(cfg_nprb) >= 1) && (int'(cfg_nprb) <= MAX_PRB) &&
                   (int'(cfg_nsym) >= 1) && (int'(cfg_nsym) <= MAX_SYM);
   assign launch = (state == IDLE) && start && legal;
   assign kill   = abort && (state != IDLE);

   // The gap only starts counting once the trailing write and the sym_done
   // pulse of the finished symbol have both gone out.
   assign gap_run  = (state == GAP) && !wr_en && !sym_done;
   assign gap_exit = gap_run && (gap_cnt == GAP_W'(GAP_CYC - 1));

   re_map_cnt #(.W(ADDR_W)) u_sc_cnt (
      .CLK   (CLK),
      .RST   (RST),
      .en    (accept && !abort),
      .clr   (launch || kill),
      .last  (n_sc - 1'b1),
      .count (sc_cnt),
      .term  (sc_term)
   );

   re_map_cnt #(.W(SYM_W)) u_sym_cnt (
      .CLK   (CLK),
      .RST   (RST),
      .en    (sym_end && !abort),
      .clr   (launch || kill),
      .last  (nsym - 1'b1),
      .count (sym_cnt),
      .term  (sym_term)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (launch) state_next = WRITE;
         WRITE: begin
            if (abort)        state_next = IDLE;
            else if (sym_end) state_next = GAP;
         end
         GAP: begin
            if (abort)         state_next = IDLE;
            else if (gap_exit) state_next = final_sym ? DONE : WRITE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         n_sc      <= '0;
         nsym      <= '0;
         cfg_err   <= 1'b0;
         final_sym <= 1'b0;
         gap_cnt   <= '0;
         wr_en     <= 1'b0;
         wr_data   <= '0;
         wr_addr   <= '0;
         last_q    <= 1'b0;
         sym_done  <= 1'b0;
         re_done   <= 1'b0;
      end else begin
         if (launch) begin
            n_sc <= ADDR_W'(cfg_nprb) * ADDR_W'(SC_PER_PRB);
            nsym <= cfg_nsym;
         end

         if ((state == IDLE) && start) cfg_err <= !legal;

         // Remember whether the symbol just finished was the last one, so the
         // gap knows whether to resume writing or close the subframe.
         if (launch || kill)            final_sym <= 1'b0;
         else if (sym_end && !abort)    final_sym <= sym_term;

         if (gap_run) gap_cnt <= gap_exit ? '0 : gap_cnt + 1'b1;
         else         gap_cnt <= '0;

         wr_en <= accept && !abort;
         if (accept) begin
            wr_data <= in_data;
            wr_addr <= sc_cnt;
         end

         // sym_done trails the final write by one cycle, so the two never
         // coincide; an abort in between cancels it.
         last_q   <= sym_end && !abort;
         sym_done <= last_q && !abort;

         re_done <= (abort && ((state == WRITE) || (state == GAP))) ||
                    (state_next == DONE);
      end
   end

endmodule

// File: tb/tb_re_map_ctrl.sv
// ----------------------------------------------------------------------------
// tb_re_map_ctrl
// Directed bench for re_map_ctrl: reset values, single-PRB timing, full
// 100-PRB/14-symbol subframe, illegal configurations, stalled input with data
// scoreboard, abort mid-symbol and reset during the gap.
// ----------------------------------------------------------------------------
module tb_re_map_ctrl;
   import re_map_ctrl_pkg::*;

   localparam int DATA_W  = 18;
   localparam int MAX_PRB = 100;
   localparam int GAP_CYC = 2;

   logic                     CLK;
   logic                     RST;
   logic                     start;
   logic [6:0]               cfg_nprb;
   logic [3:0]               cfg_nsym;
   logic                     abort;
   logic signed [DATA_W-1:0] in_data;
   logic                     in_valid;
   logic                     in_ready;
   logic [DATA_W-1:0]        wr_data;
   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic                     sym_done;
   logic                     re_done;
   logic                     busy;
   logic                     cfg_err;
   re_map_state_e            fsm_state;

   re_map_ctrl #(
      .DATA_W  (DATA_W),
      .MAX_PRB (MAX_PRB),
      .GAP_CYC (GAP_CYC)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .start     (start),
      .cfg_nprb  (cfg_nprb),
      .cfg_nsym  (cfg_nsym),
      .abort     (abort),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .wr_data   (wr_data),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .sym_done  (sym_done),
      .re_done   (re_done),
      .busy      (busy),
      .cfg_err   (cfg_err),
      .fsm_state (fsm_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // ---------------- scoreboard state ----------------
   int total = 0;
   int bad   = 0;

   logic [DATA_W-1:0] exp_q[$];
   int exp_nsc      = 12;
   int exp_addr     = 0;
   int wr_cnt       = 0;
   int wr_since_sym = 0;
   int sym_seen     = 0;
   int re_seen      = 0;
   int max_addr     = 0;
   int cyc          = 0;
   int first_wr_cyc = 0;
   int last_wr_cyc  = 0;
   int sym_cyc      = 0;
   int re_cyc       = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_stats(input int nsc);
      exp_q.delete();
      exp_nsc      = nsc;
      exp_addr     = 0;
      wr_cnt       = 0;
      wr_since_sym = 0;
      sym_seen     = 0;
      re_seen      = 0;
      max_addr     = 0;
   endtask

   // Accepted samples enter the expected queue in order.
   always @(posedge CLK) begin
      cyc++;
      if (RST && in_valid && in_ready) exp_q.push_back(in_data);
   end

   // Output monitor, sampled mid-cycle.
   always @(negedge CLK) begin
      logic [DATA_W-1:0] e;
      if (RST) begin
         if (wr_en) begin
            check("addr", 32'(wr_addr), 32'(exp_addr));
            if (exp_q.size() == 0) begin
               check("wr_unexpected", 32'(1), 32'(0));
            end else begin
               e = exp_q.pop_front();
               check("data", 32'(wr_data), 32'(e));
            end
            check("wr_sym_overlap", 32'(sym_done), 32'(0));
            if (exp_addr == exp_nsc - 1) check("rdy_drop", 32'(in_ready), 32'(0));
            exp_addr = (exp_addr == exp_nsc - 1) ? 0 : exp_addr + 1;
            if (wr_cnt == 0) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
            wr_cnt++;
            wr_since_sym++;
            if (int'(wr_addr) > max_addr) max_addr = int'(wr_addr);
         end
         if (sym_done) begin
            check("sym_len", 32'(wr_since_sym), 32'(exp_nsc));
            wr_since_sym = 0;
            sym_seen++;
            sym_cyc = cyc;
         end
         if (re_done) begin
            re_seen++;
            re_cyc = cyc;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_start(input logic [6:0] nprb, input logic [3:0] nsym);
      @(posedge CLK); #1;
      start    = 1'b1;
      cfg_nprb = nprb;
      cfg_nsym = nsym;
      @(posedge CLK); #1;
      start    = 1'b0;
   endtask

   // Feed samples until re_done is seen; optional stray start pulse mid-run.
   task automatic feed(input int budget, input bit gappy, input int start_at);
      int r0;
      int n;
      r0 = re_seen;
      n  = 0;
      while (re_seen == r0 && n < budget) begin
         @(posedge CLK); #1;
         start = (n == start_at);
         if (n == start_at) cfg_nprb = 7'd5;
         in_valid = gappy ? ($urandom_range(0, 3) != 0) : 1'b1;
         in_data  = DATA_W'($urandom);
         n++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      check("feed_timeout", 32'(re_seen != r0), 32'(1));
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(posedge CLK);
      #1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      int s0, r0, w0;

      RST      = 1'b0;
      start    = 1'b0;
      cfg_nprb = '0;
      cfg_nsym = '0;
      abort    = 1'b0;
      in_data  = '0;
      in_valid = 1'b0;

      // Reset values
      #12;
      check("rst_flags", 32'({in_ready, wr_en, sym_done, re_done, busy, cfg_err}), 32'(0));
      check("rst_wr_data", 32'(wr_data), 32'(0));
      check("rst_wr_addr", 32'(wr_addr), 32'(0));
      check("rst_state", 32'(fsm_state), 32'(IDLE));
      @(posedge CLK); #1;
      RST = 1'b1;
      idle_cycles(2);

      // 1 PRB, 1 symbol, continuous valid
      clear_stats(12);
      do_start(7'd1, 4'd1);
      @(negedge CLK);
      check("t1_busy", 32'(busy), 32'(1));
      check("t1_ready", 32'(in_ready), 32'(1));
      feed(100, 1'b0, -1);
      check("t1_wr_cnt", 32'(wr_cnt), 32'(12));
      check("t1_max_addr", 32'(max_addr), 32'(11));
      check("t1_consecutive", 32'(last_wr_cyc - first_wr_cyc), 32'(11));
      check("t1_sym_lat", 32'(sym_cyc - last_wr_cyc), 32'(1));
      check("t1_re_lat", 32'(re_cyc - sym_cyc), 32'(GAP_CYC + 1));
      check("t1_sym_cnt", 32'(sym_seen), 32'(1));
      idle_cycles(2);
      check("t1_idle", 32'(fsm_state), 32'(IDLE));
      check("t1_busy_end", 32'(busy), 32'(0));
      check("t1_re_once", 32'(re_seen), 32'(1));

      // 100 PRB, 14 symbols
      clear_stats(1200);
      do_start(7'd100, 4'd14);
      feed(20000, 1'b0, -1);
      check("t2_wr_cnt", 32'(wr_cnt), 32'(16800));
      check("t2_sym_cnt", 32'(sym_seen), 32'(14));
      check("t2_max_addr", 32'(max_addr), 32'(1199));
      idle_cycles(3);
      check("t2_re_once", 32'(re_seen), 32'(1));

      // Illegal configurations
      clear_stats(12);
      do_start(7'd0, 4'd3);
      in_valid = 1'b1;
      idle_cycles(4);
      check("t3_err_nprb0", 32'(cfg_err), 32'(1));
      check("t3_busy_nprb0", 32'(busy), 32'(0));
      check("t3_no_wr", 32'(wr_cnt), 32'(0));
      in_valid = 1'b0;
      abort = 1'b1;
      @(posedge CLK); #1;
      abort = 1'b0;
      idle_cycles(2);
      check("t3_idle_abort", 32'(re_seen), 32'(0));
      check("t3_idle_abort_st", 32'(fsm_state), 32'(IDLE));
      do_start(7'd101, 4'd3);
      idle_cycles(1);
      check("t3_err_nprb101", 32'(cfg_err), 32'(1));
      check("t3_busy_nprb101", 32'(busy), 32'(0));
      do_start(7'd1, 4'd15);
      idle_cycles(1);
      check("t3_err_nsym15", 32'(cfg_err), 32'(1));
      do_start(7'd1, 4'd0);
      idle_cycles(1);
      check("t3_err_nsym0", 32'(cfg_err), 32'(1));
      check("t3_no_wr2", 32'(wr_cnt), 32'(0));
      do_start(7'd1, 4'd1);
      @(negedge CLK);
      check("t3_err_clear", 32'(cfg_err), 32'(0));
      check("t3_busy_legal", 32'(busy), 32'(1));
      feed(100, 1'b0, -1);
      check("t3_wr_cnt", 32'(wr_cnt), 32'(12));

      // 2 PRB, 2 symbols, random valid gaps, stray start mid-run
      idle_cycles(2);
      clear_stats(24);
      do_start(7'd2, 4'd2);
      feed(1000, 1'b1, 10);
      check("t4_wr_cnt", 32'(wr_cnt), 32'(48));
      check("t4_sym_cnt", 32'(sym_seen), 32'(2));
      check("t4_q_empty", 32'(exp_q.size()), 32'(0));

      // Abort after 5 writes of symbol 3
      idle_cycles(2);
      clear_stats(12);
      do_start(7'd1, 4'd5);
      n = 0;
      while (!(sym_seen == 3 && wr_since_sym == 5) && n < 2000) begin
         @(negedge CLK); #1;
         in_valid = 1'b1;
         in_data  = DATA_W'($urandom);
         n++;
      end
      in_valid = 1'b0;
      abort    = 1'b1;
      check("t5_reach", 32'(n < 2000), 32'(1));
      @(posedge CLK); #1;
      abort = 1'b0;
      @(negedge CLK);
      check("t5_state", 32'(fsm_state), 32'(IDLE));
      check("t5_wr_en", 32'(wr_en), 32'(0));
      check("t5_sym_done", 32'(sym_done), 32'(0));
      check("t5_re_done", 32'(re_done), 32'(1));
      check("t5_busy", 32'(busy), 32'(0));
      idle_cycles(6);
      check("t5_re_once", 32'(re_seen), 32'(1));
      check("t5_sym_cnt", 32'(sym_seen), 32'(3));
      check("t5_partial", 32'(wr_since_sym), 32'(5));
      clear_stats(12);
      do_start(7'd1, 4'd2);
      feed(200, 1'b0, -1);
      check("t5_restart_wr", 32'(wr_cnt), 32'(24));
      check("t5_restart_sym", 32'(sym_seen), 32'(2));

      // Reset during GAP
      idle_cycles(2);
      clear_stats(12);
      do_start(7'd1, 4'd2);
      n = 0;
      while (sym_seen < 1 && n < 200) begin
         @(negedge CLK); #1;
         in_valid = 1'b1;
         in_data  = DATA_W'($urandom);
         n++;
      end
      check("t6_reach", 32'(n < 200), 32'(1));
      check("t6_in_gap", 32'(fsm_state), 32'(GAP));
      #1;
      RST = 1'b0;
      #1;
      check("t6_flags", 32'({in_ready, wr_en, sym_done, re_done, busy, cfg_err}), 32'(0));
      check("t6_wr_data", 32'(wr_data), 32'(0));
      check("t6_wr_addr", 32'(wr_addr), 32'(0));
      check("t6_state", 32'(fsm_state), 32'(IDLE));
      idle_cycles(2);
      RST = 1'b1;
      s0 = sym_seen;
      r0 = re_seen;
      w0 = wr_cnt;
      idle_cycles(10);
      in_valid = 1'b0;
      check("t6_no_sym", 32'(sym_seen), 32'(s0));
      check("t6_no_re", 32'(re_seen), 32'(r0));
      check("t6_no_wr", 32'(wr_cnt), 32'(w0));
      check("t6_busy", 32'(busy), 32'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
